// File: rtl/fuzzy_cmp_pkg.sv
// Shared definitions for the fuzzy-datapath comparator blocks.
//   MODE_MIN / MODE_MAX : encoding of the per-sample min/max mode bit.
//   clog2               : ceiling log2, used to size index width and tree depth.
//   level_count         : number of entries held at a given tree level.
//   reg_offset          : position of a registered level inside the flat
//                         stage-register array of min_max_tree_pipe.
// The stage-entry record {value, index, mode, valid} depends on the WIDTH
// and IDX_W of each instance. A package cannot take parameters, so each
// module that stores entries declares that record locally with this field
// order.
package fuzzy_cmp_pkg;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // ceil(n / 2^k)
  function automatic int level_count(input int n, input int k);
    return (n + (1 << k) - 1) >> k;
  endfunction

  // Levels 1..k-1 are packed back to back, so level k starts here.
  function automatic int reg_offset(input int n, input int k);
    int off;
    off = 0;
    for (int m = 1; m < k; m++) off += level_count(n, m);
    return off;
  endfunction

endpackage

// File: rtl/min_max_cell.sv
// Combinational compare-select of two tree entries.
//   mode_i      : MODE_MIN selects the strictly smaller value, MODE_MAX the
//                 strictly larger one. The compare is unsigned.
//   a_*_i       : left (lower-index) operand; it wins every tie.
//   b_*_i       : right operand.
//   win_*_o     : value and index of the selected operand.
module min_max_cell
  import fuzzy_cmp_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int IDX_W = 3
) (
  input  logic             mode_i,
  input  logic [WIDTH-1:0] a_value_i,
  input  logic [IDX_W-1:0] a_index_i,
  input  logic [WIDTH-1:0] b_value_i,
  input  logic [IDX_W-1:0] b_index_i,
  output logic [WIDTH-1:0] win_value_o,
  output logic [IDX_W-1:0] win_index_o
);

  logic b_wins;

  // Only a strict improvement lets b win, which gives the tie to a.
  always_comb begin
    b_wins = 1'b0;
    case (mode_i)
      MODE_MIN: b_wins = (b_value_i < a_value_i);
      MODE_MAX: b_wins = (b_value_i > a_value_i);
      default:  b_wins = 1'b0;
    endcase
  end

  assign win_value_o = b_wins ? b_value_i : a_value_i;
  assign win_index_o = b_wins ? b_index_i : a_index_i;

endmodule

// File: rtl/min_max_tree_pipe.sv
// Pipelined balanced binary min/max reduction of NUM_INPUTS unsigned operands.
//   clock, reset  : system clock; synchronous active-high reset clears every
//                   stage register. Reset has priority over io_start.
//   io_start      : advance enable. While low, every stage holds.
//   io_in_valid   : marks io_inputs as a real sample on an advancing cycle.
//   io_maxMin     : per-sample mode (0 = min, 1 = max).
//   io_inputs     : packed operands; operand i is io_inputs[i*WIDTH +: WIDTH].
//   io_result     : selected min or max value.
//   io_index      : lowest index among equal extrema.
//   io_out_valid  : the output stage holds a completed sample.
//   io_busy       : OR of all stage valid bits.
// Flow control: there is no back-pressure. A sample is accepted on every
// cycle with io_start=1. It is a real sample when io_in_valid=1 and a bubble
// otherwise. It leaves LEVELS advancing cycles later with io_out_valid set,
// and io_out_valid stays set for as long as the output stage holds it.
module min_max_tree_pipe
  import fuzzy_cmp_pkg::*;
#(
  parameter int NUM_INPUTS = 5,
  parameter int WIDTH      = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              io_start,
  input  logic                              io_in_valid,
  input  logic                              io_maxMin,
  input  logic [NUM_INPUTS*WIDTH-1:0]       io_inputs,
  output logic [WIDTH-1:0]                  io_result,
  output logic [clog2(NUM_INPUTS)-1:0]      io_index,
  output logic                              io_out_valid,
  output logic                              io_busy
);

  localparam int IDX_W   = clog2(NUM_INPUTS);
  localparam int LEVELS  = clog2(NUM_INPUTS);
  // All registered levels 1..LEVELS, flattened into one array.
  localparam int REG_TOT = reg_offset(NUM_INPUTS, LEVELS + 1);

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic [IDX_W-1:0] index;
    logic             mode;
    logic             valid;
  } entry_t;

  // Level 0 is the unregistered input sample.
  entry_t in_ent [NUM_INPUTS];
  entry_t node_q [REG_TOT];

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
    assign in_ent[i].value = io_inputs[i*WIDTH +: WIDTH];
    assign in_ent[i].index = IDX_W'(i);
    assign in_ent[i].mode  = io_maxMin;
    assign in_ent[i].valid = io_in_valid;
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int CNT  = level_count(NUM_INPUTS, k);
    localparam int PCNT = level_count(NUM_INPUTS, k - 1);
    localparam int OFF  = reg_offset(NUM_INPUTS, k);
    localparam int POFF = reg_offset(NUM_INPUTS, k - 1);

    for (genvar j = 0; j < CNT; j++) begin : g_ent
      entry_t left;
      entry_t node_d;

      if (k == 1) begin : g_left_in
        assign left = in_ent[2*j];
      end else begin : g_left_reg
        assign left = node_q[POFF + 2*j];
      end

      if (2*j + 1 < PCNT) begin : g_cmp
        entry_t           right;
        logic [WIDTH-1:0] win_value;
        logic [IDX_W-1:0] win_index;

        if (k == 1) begin : g_right_in
          assign right = in_ent[2*j + 1];
        end else begin : g_right_reg
          assign right = node_q[POFF + 2*j + 1];
        end

        // Every entry of a level carries the same mode and valid bits, so
        // the left entry supplies them for the next level.
        min_max_cell #(
          .WIDTH (WIDTH),
          .IDX_W (IDX_W)
        ) u_cell (
          .mode_i      (left.mode),
          .a_value_i   (left.value),
          .a_index_i   (left.index),
          .b_value_i   (right.value),
          .b_index_i   (right.index),
          .win_value_o (win_value),
          .win_index_o (win_index)
        );

        assign node_d.value = win_value;
        assign node_d.index = win_index;
        assign node_d.mode  = left.mode;
        assign node_d.valid = left.valid;
      end else begin : g_pass
        // An odd last entry is only delayed, so every path has the same latency.
        assign node_d = left;
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          node_q[OFF + j] <= '0;
        end else if (io_start) begin
          node_q[OFF + j] <= node_d;
        end
      end
    end
  end

  always_comb begin
    io_busy = 1'b0;
    for (int i = 0; i < REG_TOT; i++) io_busy = io_busy | node_q[i].valid;
  end

  // The last level holds exactly one entry, stored at the end of the array.
  assign io_result    = node_q[REG_TOT-1].value;
  assign io_index     = node_q[REG_TOT-1].index;
  assign io_out_valid = node_q[REG_TOT-1].valid;

endmodule

// File: tb/tb_min_max_tree_pipe.sv
module tb_min_max_tree_pipe;

  localparam int N = 5;
  localparam int W = 3;

  // Clock and reset
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          io_start = 1'b0;
  logic          io_in_valid = 1'b0;
  logic          io_maxMin = 1'b0;
  logic [N*W-1:0] io_inputs = '0;
  logic [W-1:0]  io_result;
  logic [2:0]    io_index;
  logic          io_out_valid;
  logic          io_busy;

  always #5 clock = ~clock;

  min_max_tree_pipe #(
    .NUM_INPUTS (N),
    .WIDTH      (W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_start     (io_start),
    .io_in_valid  (io_in_valid),
    .io_maxMin    (io_maxMin),
    .io_inputs    (io_inputs),
    .io_result    (io_result),
    .io_index     (io_index),
    .io_out_valid (io_out_valid),
    .io_busy      (io_busy)
  );

  // Scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N*W-1:0] pk(input int v0, input int v1, input int v2,
                                         input int v3, input int v4);
    logic [N*W-1:0] r;
    r = '0;
    r[0*W +: W] = W'(v0);
    r[1*W +: W] = W'(v1);
    r[2*W +: W] = W'(v2);
    r[3*W +: W] = W'(v3);
    r[4*W +: W] = W'(v4);
    return r;
  endfunction

  // Driver tasks
  task automatic drive(input logic [N*W-1:0] vals, input logic mode, input logic vld);
    io_inputs   = vals;
    io_maxMin   = mode;
    io_in_valid = vld;
  endtask

  task automatic bubble();
    drive('0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    bubble();
    repeat (3) step();
  endtask

  // One sample through an otherwise empty pipe, checked after 3 advances
  // and again one cycle later, when it must have left the output stage.
  task automatic run_sample(input string tag, input logic [N*W-1:0] vals,
                            input logic mode, input int exp_res, input int exp_idx);
    drive(vals, mode, 1'b1);
    step();
    bubble();
    step();
    step();
    check({tag, "_valid"}, int'(io_out_valid), 1);
    check({tag, "_result"}, int'(io_result), exp_res);
    check({tag, "_index"}, int'(io_index), exp_idx);
    step();
    check({tag, "_valid_drop"}, int'(io_out_valid), 0);
  endtask

  initial begin
    // Reset held 2 cycles with start high and random inputs
    reset    = 1'b1;
    io_start = 1'b1;
    io_in_valid = 1'b1;
    io_maxMin = 1'($urandom_range(0, 1));
    io_inputs = (N*W)'($urandom_range(0, 32767));
    step();
    io_inputs = (N*W)'($urandom_range(0, 32767));
    step();
    check("rst_result", int'(io_result), 0);
    check("rst_index", int'(io_index), 0);
    check("rst_valid", int'(io_out_valid), 0);
    check("rst_busy", int'(io_busy), 0);
    reset = 1'b0;
    bubble();

    // Min and max with ties
    run_sample("min", pk(5, 3, 7, 3, 6), 1'b0, 3, 1);
    run_sample("max_tie", pk(5, 3, 7, 3, 7), 1'b1, 7, 2);
    // Extremum on the odd pass-through operand
    run_sample("max_last", pk(0, 0, 0, 0, 1), 1'b1, 1, 4);
    run_sample("min_all_eq", pk(4, 4, 4, 4, 4), 1'b0, 4, 0);
    check("idle_busy", int'(io_busy), 0);

    // Streaming mixed modes
    drive(pk(1, 2, 3, 4, 5), 1'b0, 1'b1);
    step();
    drive(pk(1, 2, 3, 4, 5), 1'b1, 1'b1);
    step();
    drive(pk(0, 0, 0, 0, 0), 1'b0, 1'b1);
    step();
    check("strA_valid", int'(io_out_valid), 1);
    check("strA_result", int'(io_result), 1);
    check("strA_index", int'(io_index), 0);
    bubble();
    step();
    check("strB_valid", int'(io_out_valid), 1);
    check("strB_result", int'(io_result), 5);
    check("strB_index", int'(io_index), 4);
    step();
    check("strC_valid", int'(io_out_valid), 1);
    check("strC_result", int'(io_result), 0);
    check("strC_index", int'(io_index), 0);
    flush();
    check("str_busy_end", int'(io_busy), 0);

    // Stall: one advance, two held cycles, then two more advances
    drive(pk(1, 2, 3, 4, 5), 1'b0, 1'b1);
    step();
    io_start = 1'b0;
    drive(pk(7, 7, 7, 7, 7), 1'b1, 1'b1);
    step();
    step();
    check("stall_busy", int'(io_busy), 1);
    check("stall_valid", int'(io_out_valid), 0);
    io_start = 1'b1;
    bubble();
    step();
    check("stall_adv2_valid", int'(io_out_valid), 0);
    step();
    check("stall_valid_out", int'(io_out_valid), 1);
    check("stall_result", int'(io_result), 1);
    check("stall_index", int'(io_index), 0);
    io_start = 1'b0;
    drive(pk(6, 6, 6, 6, 6), 1'b1, 1'b1);
    step();
    step();
    check("hold_valid", int'(io_out_valid), 1);
    check("hold_result", int'(io_result), 1);
    check("hold_index", int'(io_index), 0);
    io_start = 1'b1;
    bubble();
    step();
    check("hold_release_valid", int'(io_out_valid), 0);
    flush();

    // Reset while the sample sits in level 2
    drive(pk(1, 2, 3, 4, 5), 1'b0, 1'b1);
    step();
    bubble();
    step();
    check("mid_busy_before", int'(io_busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mid_rst_valid%0d", i), int'(io_out_valid), 0);
    end
    check("mid_rst_busy", int'(io_busy), 0);

    // Bubble: data propagates, valid stays low
    drive(pk(6, 5, 4, 7, 2), 1'b0, 1'b0);
    step();
    bubble();
    step();
    step();
    check("bub_valid", int'(io_out_valid), 0);
    check("bub_result", int'(io_result), 2);
    check("bub_index", int'(io_index), 4);
    check("bub_busy", int'(io_busy), 0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/min_max_tree_pipe.md
Name: min_max_tree_pipe

Overview:
- Parametrised successor to the fixed 5-input min comparator chain in the fuzzy datapath.
- Reduces NUM_INPUTS unsigned operands to one min or max through a balanced, registered binary tree.
- Mode is selectable per sample. Outputs also carry the winning operand's index and a valid flag.
- Sits between the fuzzification stage and the rule/defuzzification stage; accepts one new sample per advancing cycle.

Parameters:
- NUM_INPUTS, 5, number of operands; legal range 2..64.
- WIDTH, 3, operand width in bits; legal range 1..32.
- IDX_W, derived = clog2(NUM_INPUTS), width of the index output.
- LEVELS, derived = clog2(NUM_INPUTS), pipeline depth in advancing cycles.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- io_start  in  1  pipeline advance enable; when low, every stage holds.
- io_in_valid  in  1  marks io_inputs as a real sample on an advancing cycle.
- io_maxMin  in  1  per-sample mode: 0 = min, 1 = max.
- io_inputs  in  NUM_INPUTS*WIDTH  packed operands; operand i occupies bits [i*WIDTH +: WIDTH].
- io_result  out  WIDTH  selected min or max value.
- io_index  out  IDX_W  index of the selected operand.
- io_out_valid  out  1  io_result and io_index hold a completed sample.
- io_busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset, synchronous and active-high: all stage data, index, mode and valid registers clear to 0. Therefore io_result=0, io_index=0, io_out_valid=0, io_busy=0 on the cycle after reset is sampled high. Reset has priority over io_start.
- Level k holds ceil(NUM_INPUTS/2^k) entries. Each entry is {value, index, mode, valid}.
- Entry j of level k+1 is the compare-select of entries 2j and 2j+1 of level k.
- When a level has an odd count, its last entry passes through a register unchanged, so all paths have equal latency.
- Mode and valid are captured at level 1 and travel with the data. Each stage uses its own carried mode, so back-to-back samples may alternate min/max.
- Compare is unsigned on the full WIDTH.
  - Min mode selects the strictly smaller operand. Max mode selects the strictly larger operand.
  - Ties: the left (lower-index) operand wins, so io_index is the lowest index among equal extrema.
- Advance rule: on a cycle with io_start=1, every level registers from the level before it, and level 1 registers from io_inputs, io_maxMin and io_in_valid. On a cycle with io_start=0, all registers hold, including outputs.
- Latency: a sample presented on advancing cycle t appears on io_result/io_index with io_out_valid=1 after LEVELS advancing cycles. Example: NUM_INPUTS=5 gives 3 levels (5->3->2->1).
- Throughput: one sample per advancing cycle; there is no internal back-pressure.
- io_in_valid=0 on an advancing cycle injects a bubble. Data still propagates, but the valid bit is 0.
- io_out_valid is asserted only while a valid sample occupies the output stage. It stays asserted across stalls.
- Reset mid-operation discards every in-flight sample; no partial result is emitted.
- NUM_INPUTS a power of two: no pass-through registers are generated.

Decomposition:
- Shared package fuzzy_cmp_pkg holds:
  - MODE_MIN=0, MODE_MAX=1;
  - clog2 function;
  - a stage-entry struct/typedef {value, index, mode, valid} parametrised on WIDTH/IDX_W.
- One combinational sub-module, min_max_cell. It takes two entries plus a mode, and returns the winning value/index under the tie rule.
- The top instantiates min_max_cell in a generate loop per level, plus the stage registers.

Test Plan:
- Reset: hold reset 2 cycles with io_start=1 and random inputs -> io_result=0, io_index=0, io_out_valid=0, io_busy=0.
- Min (N=5, W=3): inputs [5,3,7,3,6], mode=0, valid=1, start=1 -> after 3 cycles io_result=3, io_index=1, io_out_valid=1 for exactly one cycle.
- Max with tie: inputs [5,3,7,3,7], mode=1 -> io_result=7, io_index=2.
- Streaming mixed modes: samples A=[1,2,3,4,5] min, B=[1,2,3,4,5] max, C=[0,0,0,0,0] min on consecutive cycles -> outputs on cycles 3,4,5 are (1,0),(5,4),(0,0).
- Stall: present A, then drop io_start for 2 cycles after the first advance -> result appears at the 3rd advancing cycle (cycle 5); outputs hold while io_start=0.
- Reset mid-flight and bubble: reset asserted when A is at level 2 -> no valid output follows. Separately, io_in_valid=0 with start=1 -> io_out_valid stays 0 while io_result still updates.
